dm_slave_arbiter: RTL and testbench

//  Shares the debug module's single slave memory port between the core's instruction-fetch
//  (I) and data (D) ports. Round-robin arbitration with pipelined, fixed-latency responses

---
 rtl/dm_slave_arbiter_pkg.sv | 25 ++
 rtl/dm_slave_arbiter_if.sv | 59 +++++
 rtl/dm_slave_arbiter_resp_pipe.sv | 32 +++
 rtl/dm_slave_arbiter.sv | 103 ++++++++++
 tb/tb_dm_slave_arbiter.sv | 372 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dm_slave_arbiter_pkg.sv
// Shared types and the debug-window decode helper for dm_slave_arbiter.
package dm_slave_arbiter_pkg;

    // Owner of a granted request; also the encoding of the last_grant register.
    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

    // One in-flight response slot: valid, who it goes back to, and whether it is a local error.
    typedef struct packed {
        logic   vld;
        owner_e owner;
        logic   err;
    } resp_entry_t;

    // True when addr falls inside [base, base+span). Callers zero-extend to 64 bits so the
    // upper bound cannot wrap for windows ending at the top of a 32-bit address space.
    function automatic logic in_window(input logic [63:0] addr,
                                       input logic [63:0] base,
                                       input logic [63:0] span);
        return (addr >= base) && (addr < (base + span));
    endfunction

endpackage

// File: rtl/dm_slave_arbiter_if.sv
// Bus bundle between the core fabric (I/D ports), the arbiter and the debug slave port.
// Optional macro DM_ARB_LOCK_EN adds the dmem_lock_i signal.
interface dm_slave_arbiter_if #(
    parameter int BusWidth = 32
);
    logic                  imem_req_i;
    logic [BusWidth-1:0]   imem_addr_i;
    logic                  imem_gnt_o;
    logic                  imem_rvalid_o;
    logic [BusWidth-1:0]   imem_rdata_o;
    logic                  imem_err_o;

    logic                  dmem_req_i;
    logic                  dmem_we_i;
    logic [BusWidth-1:0]   dmem_addr_i;
    logic [BusWidth/8-1:0] dmem_be_i;
    logic [BusWidth-1:0]   dmem_wdata_i;
    logic                  dmem_gnt_o;
    logic                  dmem_rvalid_o;
    logic [BusWidth-1:0]   dmem_rdata_o;
    logic                  dmem_err_o;
`ifdef DM_ARB_LOCK_EN
    logic                  dmem_lock_i;
`endif

    logic                  slave_req_o;
    logic                  slave_we_o;
    logic [BusWidth-1:0]   slave_addr_o;
    logic [BusWidth/8-1:0] slave_be_o;
    logic [BusWidth-1:0]   slave_wdata_o;
    logic [BusWidth-1:0]   slave_rdata_i;

    // Environment side: the core's I/D requesters plus the debug slave memory.
    modport master (
        output imem_req_i, imem_addr_i,
        input  imem_gnt_o, imem_rvalid_o, imem_rdata_o, imem_err_o,
        output dmem_req_i, dmem_we_i, dmem_addr_i, dmem_be_i, dmem_wdata_i,
        input  dmem_gnt_o, dmem_rvalid_o, dmem_rdata_o, dmem_err_o,
`ifdef DM_ARB_LOCK_EN
        output dmem_lock_i,
`endif
        input  slave_req_o, slave_we_o, slave_addr_o, slave_be_o, slave_wdata_o,
        output slave_rdata_i
    );

    // Arbiter side.
    modport slave (
        input  imem_req_i, imem_addr_i,
        output imem_gnt_o, imem_rvalid_o, imem_rdata_o, imem_err_o,
        input  dmem_req_i, dmem_we_i, dmem_addr_i, dmem_be_i, dmem_wdata_i,
        output dmem_gnt_o, dmem_rvalid_o, dmem_rdata_o, dmem_err_o,
`ifdef DM_ARB_LOCK_EN
        input  dmem_lock_i,
`endif
        output slave_req_o, slave_we_o, slave_addr_o, slave_be_o, slave_wdata_o,
        input  slave_rdata_i
    );

endinterface

// File: rtl/dm_slave_arbiter_resp_pipe.sv
// Fixed-depth shift register of response entries; depth equals the slave read latency so the
// tail entry lines up with the cycle the slave presents its read data.
module dm_slave_arbiter_resp_pipe
    import dm_slave_arbiter_pkg::*;
#(
    parameter int RdLatency = 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  resp_entry_t entry_in,
    output resp_entry_t entry_out
);

    resp_entry_t entry_p [RdLatency];

    // Shift one slot per cycle; reset flushes every in-flight response.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < RdLatency; i++) begin
                entry_p[i] <= '0;
            end
        end else begin
            entry_p[0] <= entry_in;
            for (int i = 1; i < RdLatency; i++) begin
                entry_p[i] <= entry_p[i-1];
            end
        end
    end

    assign entry_out = entry_p[RdLatency-1];

endmodule

// File: rtl/dm_slave_arbiter.sv
// Round-robin arbiter sharing the debug module's slave port between the core I and D ports.
// Grants are combinational; responses come back RdLatency cycles later to the owning port.
// Requests outside the debug window are granted but answered locally with err=1.
// Optional macro DM_ARB_LOCK_EN: dmem_lock_i keeps the slave reserved for D while it holds it.
module dm_slave_arbiter
    import dm_slave_arbiter_pkg::*;
#(
    parameter int                 BusWidth      = 32,
    parameter logic [BusWidth-1:0] DmBaseAddress = 'h1000,
    parameter logic [BusWidth-1:0] DmAddrSpan    = 'h1000,
    parameter int                 RdLatency     = 1
) (
    input logic              clk_i,
    input logic              rst_ni,
    dm_slave_arbiter_if.slave bus
);

    owner_e              last_grant;
    logic                lock_hold;
    logic                gnt_i;
    logic                gnt_d;
    logic                any_gnt;
    logic                hit;
    logic                fwd;
    logic                rv_i;
    logic                rv_d;
    logic [BusWidth-1:0] addr_sel;
    resp_entry_t         resp_in;
    resp_entry_t         resp_tail;

`ifdef DM_ARB_LOCK_EN
    assign lock_hold = bus.dmem_lock_i && (last_grant == OWN_D);
`else
    assign lock_hold = 1'b0;
`endif

    // Grant selection: a conflict goes to the port that did not win last; a held lock keeps I out.
    // Grants are gated by reset so nothing is accepted while the pipe is being flushed.
    always_comb begin
        gnt_i = 1'b0;
        gnt_d = 1'b0;
        if (rst_ni) begin
            if (lock_hold) begin
                gnt_d = bus.dmem_req_i;
            end else if (bus.imem_req_i && bus.dmem_req_i) begin
                gnt_d = (last_grant == OWN_I);
                gnt_i = (last_grant == OWN_D);
            end else begin
                gnt_i = bus.imem_req_i;
                gnt_d = bus.dmem_req_i;
            end
        end
    end

    // Winner mux and window decode; only in-window winners reach the slave, all fields zero otherwise.
    always_comb begin
        any_gnt           = gnt_i | gnt_d;
        addr_sel          = gnt_d ? bus.dmem_addr_i : bus.imem_addr_i;
        hit               = in_window(64'(addr_sel), 64'(DmBaseAddress), 64'(DmAddrSpan));
        fwd               = any_gnt & hit;
        bus.imem_gnt_o    = gnt_i;
        bus.dmem_gnt_o    = gnt_d;
        bus.slave_req_o   = fwd;
        bus.slave_we_o    = fwd & gnt_d & bus.dmem_we_i;
        bus.slave_addr_o  = fwd ? addr_sel : '0;
        bus.slave_be_o    = !fwd ? '0 : (gnt_d ? bus.dmem_be_i : '1);
        bus.slave_wdata_o = (fwd && gnt_d) ? bus.dmem_wdata_i : '0;
        resp_in.vld       = any_gnt;
        resp_in.owner     = gnt_d ? OWN_D : OWN_I;
        resp_in.err       = any_gnt & ~hit;
    end

    // Remember who won the most recent grant for the next conflict.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_grant <= OWN_I;
        end else if (any_gnt) begin
            last_grant <= gnt_d ? OWN_D : OWN_I;
        end
    end

    dm_slave_arbiter_resp_pipe #(
        .RdLatency (RdLatency)
    ) u_resp_pipe (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .entry_in  (resp_in),
        .entry_out (resp_tail)
    );

    // Route the tail response to its owner; error responses and the other port see zero data.
    always_comb begin
        rv_i              = resp_tail.vld && (resp_tail.owner == OWN_I);
        rv_d              = resp_tail.vld && (resp_tail.owner == OWN_D);
        bus.imem_rvalid_o = rv_i;
        bus.imem_err_o    = rv_i & resp_tail.err;
        bus.imem_rdata_o  = (rv_i && !resp_tail.err) ? bus.slave_rdata_i : '0;
        bus.dmem_rvalid_o = rv_d;
        bus.dmem_err_o    = rv_d & resp_tail.err;
        bus.dmem_rdata_o  = (rv_d && !resp_tail.err) ? bus.slave_rdata_i : '0;
    end

endmodule

// File: tb/tb_dm_slave_arbiter.sv
// Self-checking bench for dm_slave_arbiter: a RdLatency=1 instance driven by directed and random
// traffic against a queue-based reference model, and a RdLatency=3 instance for latency/reset.
// Define DM_ARB_LOCK_EN to include the bus-lock scenario.
module tb_dm_slave_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    always #5 clk = ~clk;

    dm_slave_arbiter_if #(.BusWidth(32)) a1 ();
    dm_slave_arbiter_if #(.BusWidth(32)) a3 ();

    dm_slave_arbiter #(.BusWidth(32), .DmBaseAddress(32'h1000), .DmAddrSpan(32'h1000), .RdLatency(1))
        u_lat1 (.clk_i(clk), .rst_ni(rst_n), .bus(a1));
    dm_slave_arbiter #(.BusWidth(32), .DmBaseAddress(32'h1000), .DmAddrSpan(32'h1000), .RdLatency(3))
        u_lat3 (.clk_i(clk), .rst_ni(rst_n), .bus(a3));

    // Reference model state: who won last, and the responses still owed (in grant order).
    typedef struct {
        int          due;
        logic        own_d;
        logic        err;
        logic        wr;
        logic [31:0] data;
    } exp_t;
    exp_t q[$];
    logic last_d = 1'b0;
    logic lock_m = 1'b0;

    // Observations of the most recent checked cycle, for scenario-level checks.
    logic        o_gi, o_gd, o_sreq, o_rvi, o_rvd, o_erri, o_errd;
    logic [31:0] o_rdi, o_rdd;
    logic        eg_i, eg_d;

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        return 32'hCAFE0000 + ((a - 32'h1000) >> 2);
    endfunction

    function automatic logic in_win(input logic [31:0] a);
        return (a >= 32'h1000) && (a < 32'h2000);
    endfunction

    function automatic logic [31:0] rand_addr();
        case ($urandom % 8)
            0:       return 32'h0000_0FFC;
            1:       return 32'h0000_2000;
            2:       return 32'h0000_1FFC;
            3:       return $urandom & ~32'h3;
            default: return 32'h1000 + (($urandom % 32'h1000) & ~32'h3);
        endcase
    endfunction

    // One checked cycle of the RdLatency=1 instance. Inputs are already applied.
    task automatic cycle1();
        logic        any, win, hit_m, we_m;
        logic [31:0] a, nxt, exp_rdi, exp_rdd;
        logic [69:0] exp_s, got_s;
        logic        rvi, rvd, ei, ed, skip_d;
        exp_t        r, e;
        @(negedge clk);
        eg_i = 1'b0;
        eg_d = 1'b0;
        if (lock_m && last_d) begin
            eg_d = a1.dmem_req_i;
        end else if (a1.imem_req_i && a1.dmem_req_i) begin
            eg_d = !last_d;
            eg_i = last_d;
        end else begin
            eg_i = a1.imem_req_i;
            eg_d = a1.dmem_req_i;
        end
        n_checks++;
        if (a1.imem_gnt_o !== eg_i || a1.dmem_gnt_o !== eg_d) begin
            n_fail++;
            $display("FAIL grant cyc=%0d got i=%b d=%b expected i=%b d=%b",
                     cyc, a1.imem_gnt_o, a1.dmem_gnt_o, eg_i, eg_d);
        end
        any   = eg_i | eg_d;
        a     = eg_d ? a1.dmem_addr_i : a1.imem_addr_i;
        win   = in_win(a);
        hit_m = any && win;
        we_m  = hit_m && eg_d && a1.dmem_we_i;
        exp_s = {hit_m, we_m, hit_m ? a : 32'h0, hit_m ? (eg_d ? a1.dmem_be_i : 4'hF) : 4'h0,
                 (hit_m && eg_d) ? a1.dmem_wdata_i : 32'h0};
        got_s = {a1.slave_req_o, a1.slave_we_o, a1.slave_addr_o, a1.slave_be_o, a1.slave_wdata_o};
        n_checks++;
        if (got_s !== exp_s) begin
            n_fail++;
            $display("FAIL slave_fields cyc=%0d got %h expected %h", cyc, got_s, exp_s);
        end
        rvi = 1'b0; rvd = 1'b0; ei = 1'b0; ed = 1'b0;
        exp_rdi = 32'h0; exp_rdd = 32'h0; skip_d = 1'b0;
        if (q.size() > 0 && q[0].due == cyc) begin
            r = q.pop_front();
            if (r.own_d) begin
                rvd = 1'b1; ed = r.err; exp_rdd = r.data; skip_d = r.wr && !r.err;
            end else begin
                rvi = 1'b1; ei = r.err; exp_rdi = r.data;
            end
        end
        n_checks++;
        if (a1.imem_rvalid_o !== rvi || a1.dmem_rvalid_o !== rvd ||
            a1.imem_err_o !== ei || a1.dmem_err_o !== ed) begin
            n_fail++;
            $display("FAIL response_flags cyc=%0d got rv i=%b d=%b err i=%b d=%b expected rv i=%b d=%b err i=%b d=%b",
                     cyc, a1.imem_rvalid_o, a1.dmem_rvalid_o, a1.imem_err_o, a1.dmem_err_o, rvi, rvd, ei, ed);
        end
        n_checks++;
        if (a1.imem_rdata_o !== exp_rdi || (!skip_d && a1.dmem_rdata_o !== exp_rdd)) begin
            n_fail++;
            $display("FAIL response_data cyc=%0d got i=%h d=%h expected i=%h d=%h",
                     cyc, a1.imem_rdata_o, a1.dmem_rdata_o, exp_rdi, exp_rdd);
        end
        if (any) begin
            e.due   = cyc + 1;
            e.own_d = eg_d;
            e.err   = !win;
            e.wr    = eg_d && a1.dmem_we_i;
            e.data  = (!win || e.wr) ? 32'h0 : mem_val(a);
            q.push_back(e);
            last_d  = eg_d;
        end
        o_gi = a1.imem_gnt_o;     o_gd = a1.dmem_gnt_o;     o_sreq = a1.slave_req_o;
        o_rvi = a1.imem_rvalid_o; o_rvd = a1.dmem_rvalid_o;
        o_erri = a1.imem_err_o;   o_errd = a1.dmem_err_o;
        o_rdi = a1.imem_rdata_o;  o_rdd = a1.dmem_rdata_o;
        nxt = (a1.slave_req_o && !a1.slave_we_o) ? mem_val(a1.slave_addr_o) : $urandom;
        @(posedge clk);
        #1;
        cyc++;
        a1.slave_rdata_i = nxt;
    endtask

    task automatic drain();
        a1.imem_req_i = 1'b0;
        a1.dmem_req_i = 1'b0;
        repeat (3) cycle1();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a1.imem_req_i = 1'b1; a1.imem_addr_i = 32'h1008;
        a1.dmem_req_i = 1'b1; a1.dmem_addr_i = 32'h100C; a1.dmem_we_i = 1'b0; a1.dmem_be_i = 4'hF;
        a3.imem_req_i = 1'b1; a3.imem_addr_i = 32'h1008;
        a3.dmem_req_i = 1'b1; a3.dmem_addr_i = 32'h100C;
        @(negedge clk);
        n_checks++;
        if ({a1.imem_gnt_o, a1.dmem_gnt_o, a1.imem_rvalid_o, a1.dmem_rvalid_o, a1.slave_req_o,
             a3.imem_gnt_o, a3.dmem_gnt_o, a3.slave_req_o} !== 8'h0) begin
            n_fail++;
            $display("FAIL reset_outputs got gnt1=%b%b rv1=%b%b sreq1=%b gnt3=%b%b sreq3=%b expected all 0",
                     a1.imem_gnt_o, a1.dmem_gnt_o, a1.imem_rvalid_o, a1.dmem_rvalid_o, a1.slave_req_o,
                     a3.imem_gnt_o, a3.dmem_gnt_o, a3.slave_req_o);
        end
        n_checks++;
        if ({a1.imem_rdata_o, a1.dmem_rdata_o, a1.slave_addr_o} !== 96'h0) begin
            n_fail++;
            $display("FAIL reset_data got %h %h %h expected 0", a1.imem_rdata_o, a1.dmem_rdata_o, a1.slave_addr_o);
        end
        @(posedge clk);
        #1;
        cyc++;
        rst_n  = 1'b1;
        last_d = 1'b0;
        q.delete();
        a3.imem_req_i = 1'b0;
        a3.dmem_req_i = 1'b0;
        cycle1();
        n_checks++;
        if (o_gd !== 1'b1 || o_gi !== 1'b0) begin
            n_fail++;
            $display("FAIL first_conflict got i=%b d=%b expected i=0 d=1", o_gi, o_gd);
        end
        a1.dmem_req_i = 1'b0;
        cycle1();
        drain();
    endtask

    task automatic test_single_read();
        a1.imem_req_i  = 1'b1;
        a1.imem_addr_i = 32'h1004;
        cycle1();
        n_checks++;
        if (o_gi !== 1'b1) begin
            n_fail++;
            $display("FAIL single_read_gnt got %b expected 1", o_gi);
        end
        a1.imem_req_i = 1'b0;
        cycle1();
        n_checks++;
        if (o_rvi !== 1'b1 || o_rdi !== 32'hCAFE0001 || o_erri !== 1'b0) begin
            n_fail++;
            $display("FAIL single_read_resp got rvalid=%b rdata=%h err=%b expected 1 cafe0001 0", o_rvi, o_rdi, o_erri);
        end
        drain();
    endtask

    task automatic test_alternate();
        logic [5:0] got;
        got = '0;
        a1.imem_req_i = 1'b1; a1.imem_addr_i = 32'h1100;
        a1.dmem_req_i = 1'b1; a1.dmem_addr_i = 32'h1200; a1.dmem_we_i = 1'b0; a1.dmem_be_i = 4'hF;
        for (int k = 0; k < 6; k++) begin
            cycle1();
            got[5-k] = o_gd;
            if (o_gd) a1.dmem_addr_i = 32'h1000 + (($urandom % 32'h1000) & ~32'h3);
            if (o_gi) a1.imem_addr_i = 32'h1000 + (($urandom % 32'h1000) & ~32'h3);
        end
        drain();
        n_checks++;
        if (got !== 6'b101010) begin
            n_fail++;
            $display("FAIL alternate_pattern got %b expected 101010 (1=D)", got);
        end
    endtask

    task automatic test_oob_write();
        a1.dmem_req_i = 1'b1; a1.dmem_we_i = 1'b1; a1.dmem_addr_i = 32'h2000;
        a1.dmem_be_i = 4'hF;  a1.dmem_wdata_i = 32'h12345678;
        cycle1();
        n_checks++;
        if (o_gd !== 1'b1 || o_sreq !== 1'b0) begin
            n_fail++;
            $display("FAIL oob_grant got gnt=%b slave_req=%b expected 1 0", o_gd, o_sreq);
        end
        a1.dmem_req_i = 1'b0;
        a1.dmem_we_i  = 1'b0;
        cycle1();
        n_checks++;
        if (o_rvd !== 1'b1 || o_errd !== 1'b1 || o_rdd !== 32'h0) begin
            n_fail++;
            $display("FAIL oob_resp got rvalid=%b err=%b rdata=%h expected 1 1 0", o_rvd, o_errd, o_rdd);
        end
        drain();
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            if (!a1.imem_req_i || eg_i) begin
                a1.imem_req_i  = ($urandom % 4) != 0;
                a1.imem_addr_i = rand_addr();
            end else if ($urandom % 8 == 0) begin
                a1.imem_req_i = 1'b0;
            end
            if (!a1.dmem_req_i || eg_d) begin
                a1.dmem_req_i   = ($urandom % 4) != 0;
                a1.dmem_we_i    = $urandom % 2;
                a1.dmem_addr_i  = rand_addr();
                a1.dmem_be_i    = 4'($urandom);
                a1.dmem_wdata_i = $urandom;
            end else if ($urandom % 8 == 0) begin
                a1.dmem_req_i = 1'b0;
            end
            cycle1();
        end
        drain();
    endtask

    task automatic test_lat3();
        logic [31:0] ad [3];
        logic [31:0] sp [3];
        logic [31:0] rd_now;
        logic        exp_rv;
        ad = '{32'h1010, 32'h1020, 32'h1030};
        sp = '{32'h0, 32'h0, 32'h0};
        a3.dmem_we_i = 1'b0;
        a3.dmem_be_i = 4'hF;
        for (int pass = 0; pass < 2; pass++) begin
            for (int k = 0; k < 9; k++) begin
                if (pass == 1 && k == 2) rst_n = 1'b0;
                if (pass == 1 && k == 4) rst_n = 1'b1;
                a3.dmem_req_i  = (k < 3);
                a3.dmem_addr_i = ad[k % 3];
                @(negedge clk);
                n_checks++;
                if (a3.dmem_gnt_o !== ((pass == 0) ? (k < 3) : (k < 2))) begin
                    n_fail++;
                    $display("FAIL lat3_gnt pass=%0d k=%0d got %b", pass, k, a3.dmem_gnt_o);
                end
                exp_rv = (pass == 0) && (k >= 3) && (k <= 5);
                n_checks++;
                if (a3.dmem_rvalid_o !== exp_rv || a3.imem_rvalid_o !== 1'b0 ||
                    (exp_rv && a3.dmem_rdata_o !== mem_val(ad[(k + 3) % 3]))) begin
                    n_fail++;
                    $display("FAIL lat3_resp pass=%0d k=%0d got rvalid=%b rdata=%h expected rvalid=%b rdata=%h",
                             pass, k, a3.dmem_rvalid_o, a3.dmem_rdata_o, exp_rv, mem_val(ad[(k + 3) % 3]));
                end
                rd_now = (a3.slave_req_o && !a3.slave_we_o) ? mem_val(a3.slave_addr_o) : $urandom;
                @(posedge clk);
                #1;
                cyc++;
                sp[2] = sp[1]; sp[1] = sp[0]; sp[0] = rd_now;
                a3.slave_rdata_i = sp[2];
            end
        end
        a3.dmem_req_i = 1'b0;
        last_d = 1'b0;
        q.delete();
    endtask

`ifdef DM_ARB_LOCK_EN
    task automatic test_lock();
        logic held_off;
        held_off = 1'b1;
        a1.dmem_lock_i = 1'b0; lock_m = 1'b0;
        a1.dmem_req_i = 1'b1; a1.dmem_we_i = 1'b0; a1.dmem_addr_i = 32'h1040; a1.dmem_be_i = 4'hF;
        cycle1();
        a1.dmem_lock_i = 1'b1; lock_m = 1'b1;
        a1.imem_req_i = 1'b1; a1.imem_addr_i = 32'h1080;
        for (int k = 0; k < 4; k++) begin
            cycle1();
            if (o_gi !== 1'b0 || o_gd !== 1'b1) held_off = 1'b0;
        end
        n_checks++;
        if (!held_off) begin
            n_fail++;
            $display("FAIL lock_hold got I granted or D not granted while locked, expected i=0 d=1");
        end
        a1.dmem_lock_i = 1'b0; lock_m = 1'b0;
        cycle1();
        n_checks++;
        if (o_gi !== 1'b1 || o_gd !== 1'b0) begin
            n_fail++;
            $display("FAIL lock_release got i=%b d=%b expected i=1 d=0", o_gi, o_gd);
        end
        drain();
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL timeout bench did not complete within 1ms");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        a1.imem_req_i = 1'b0; a1.imem_addr_i = '0;
        a1.dmem_req_i = 1'b0; a1.dmem_we_i = 1'b0; a1.dmem_addr_i = '0;
        a1.dmem_be_i = '0;    a1.dmem_wdata_i = '0; a1.slave_rdata_i = '0;
        a3.imem_req_i = 1'b0; a3.imem_addr_i = '0;
        a3.dmem_req_i = 1'b0; a3.dmem_we_i = 1'b0; a3.dmem_addr_i = '0;
        a3.dmem_be_i = '0;    a3.dmem_wdata_i = '0; a3.slave_rdata_i = '0;
`ifdef DM_ARB_LOCK_EN
        a1.dmem_lock_i = 1'b0;
        a3.dmem_lock_i = 1'b0;
`endif
        eg_i = 1'b0;
        eg_d = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_single_read();
        test_alternate();
        test_oob_write();
        test_random();
        test_lat3();
`ifdef DM_ARB_LOCK_EN
        test_lock();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
